// File: rtl/bus_master_if.sv
// bus_master_if: master-side bus front end. Queues local commands, requests the bus for the head entry,
// runs the transfer while granted and retires it on the ack falling edge. Watchdog abort under BMIF_TIMEOUT_EN.
module bus_master_if #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              req,
  output logic              slave_id,
  input  logic              gnt,
  input  logic              ack,
  output logic              bus_en,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int          PW       = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = DEPTH[PW:0];

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_XFER = 3'd2,
    S_ACKH = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic              we_mem_q    [DEPTH];
  logic [ADDR_W-1:0] addr_mem_q  [DEPTH];
  logic [DATA_W-1:0] wdata_mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [PW:0]       count_q, count_d;
  logic              cmd_ready_q;
  logic              push_s, pop_s;

  logic              req_q, req_d;
  logic              slave_id_q, slave_id_d;
  logic              bus_en_q, bus_en_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  assign push_s = cmd_valid & cmd_ready_q;

  always_ff @(posedge clk) begin
    if (push_s) begin
      we_mem_q[wr_ptr_q]    <= cmd_we;
      addr_mem_q[wr_ptr_q]  <= cmd_addr;
      wdata_mem_q[wr_ptr_q] <= cmd_wdata;
    end
  end

  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Ready is registered, so it looks ahead at the post-update occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cmd_ready_q <= 1'b1;
    end else begin
      if (push_s) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_s)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q     <= count_d;
      cmd_ready_q <= (count_d != FULL_CNT);
    end
  end

`ifdef BMIF_TIMEOUT_EN
  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LIM = TIMEOUT[TW-1:0];

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          busy_s, tmo_hit_s;
  logic          rsp_err_q, rsp_err_d;

  assign busy_s    = (state_q == S_XFER) || (state_q == S_ACKH);
  assign tmo_hit_s = busy_s && ((tmo_cnt_q + 1'b1) == TMO_LIM);

  always_comb begin
    if (state_q == S_REQ && gnt) begin
      tmo_cnt_d = '0;
    end else if (busy_s) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tmo_cnt_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  logic tmo_unused_s;
  assign tmo_unused_s = (TIMEOUT != 32'd0);
  assign rsp_err      = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pop_s       = 1'b0;
    req_d       = req_q;
    slave_id_d  = slave_id_q;
    bus_en_d    = bus_en_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
`ifdef BMIF_TIMEOUT_EN
    rsp_err_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d    = S_REQ;
          req_d      = 1'b1;
          slave_id_d = addr_mem_q[rd_ptr_q][ADDR_W-1];
        end else begin
          state_d = S_IDLE;
        end
      end
      S_REQ: begin
        if (gnt) begin
          state_d     = S_XFER;
          bus_en_d    = 1'b1;
          bus_we_d    = we_mem_q[rd_ptr_q];
          bus_addr_d  = addr_mem_q[rd_ptr_q];
          bus_wdata_d = wdata_mem_q[rd_ptr_q];
        end else begin
          state_d = S_REQ;
        end
      end
      S_XFER: begin
        if (ack) begin
          state_d = S_ACKH;
          if (!bus_we_q) rsp_rdata_d = bus_rdata;
          else           rsp_rdata_d = rsp_rdata_q;
        end else begin
          state_d = S_XFER;
        end
      end
      S_ACKH: begin
        // Keep recapturing while ack is high; the last ack-high sample is returned.
        if (ack) begin
          state_d = S_ACKH;
          if (!bus_we_q) rsp_rdata_d = bus_rdata;
          else           rsp_rdata_d = rsp_rdata_q;
        end else begin
          state_d     = S_GAP;
          pop_s       = 1'b1;
          rsp_valid_d = 1'b1;
          req_d       = 1'b0;
          bus_en_d    = 1'b0;
        end
      end
      S_GAP: begin
        if (!gnt) state_d = S_IDLE;
        else      state_d = S_GAP;
      end
      default: begin
        state_d  = S_IDLE;
        req_d    = 1'b0;
        bus_en_d = 1'b0;
      end
    endcase
`ifdef BMIF_TIMEOUT_EN
    // A normal retire on the ack falling edge wins over a coincident timeout.
    if (tmo_hit_s && !(state_q == S_ACKH && !ack)) begin
      state_d     = S_GAP;
      pop_s       = 1'b1;
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
      rsp_rdata_d = rsp_rdata_q;
      req_d       = 1'b0;
      bus_en_d    = 1'b0;
    end else begin
      rsp_err_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      req_q       <= 1'b0;
      slave_id_q  <= 1'b0;
      bus_en_q    <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      slave_id_q  <= slave_id_d;
      bus_en_q    <= bus_en_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign req       = req_q;
  assign slave_id  = slave_id_q;
  assign bus_en    = bus_en_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_bus_master_if.sv
// Scoreboard bench for bus_master_if: the bench plays arbiter and slave, a monitor checks every response.
module tb_bus_master_if;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_we;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       req, slave_id, gnt, ack;
  logic       bus_en, bus_we;
  logic [7:0] bus_addr, bus_wdata, bus_rdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;

  always #5 clk = ~clk;

  bus_master_if #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .req(req), .slave_id(slave_id), .gnt(gnt), .ack(ack),
    .bus_en(bus_en), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  typedef struct {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rd0;      // rdata on the first ack-high cycle
    logic [7:0] rdf;      // rdata on the last ack-high cycle
    int         ack_len;  // 0 means ack is never raised
    int         gnt_dly;
    int         hold;
    logic [7:0] exp_rd;
    logic       exp_err;
  } cmd_t;

  cmd_t       exp_q[$];
  cmd_t       plan_q[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_last = 8'h00;
  bit         hold_gnt = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we      = 1'($urandom_range(0, 1));
    c.addr    = 8'($urandom);
    c.wdata   = 8'($urandom);
    c.rd0     = 8'($urandom);
    c.rdf     = 8'($urandom);
    c.ack_len = $urandom_range(1, 3);
    c.gnt_dly = $urandom_range(0, 3);
    c.hold    = $urandom_range(0, 2);
    c.exp_rd  = 8'h00;
    c.exp_err = 1'b0;
    return c;
  endfunction

  // Reference model: responses come back in push order; a read returns the data seen on its
  // last ack-high cycle, anything else leaves the previously returned read data in place.
  task automatic push_cmd(input cmd_t c_in);
    cmd_t c;
    int   w;
    c = c_in;
    w = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && w < 1000) begin
      w++;
      @(negedge clk);
    end
    if (cmd_ready !== 1'b1) begin
      fail_now("push_ready_wait");
      return;
    end
    c.exp_err = (c.ack_len == 0);
    if (!c.we && c.ack_len > 0) model_last = c.rdf;
    c.exp_rd = model_last;
    exp_q.push_back(c);
    plan_q.push_back(c);
    cmd_valid = 1'b1;
    cmd_we    = c.we;
    cmd_addr  = c.addr;
    cmd_wdata = c.wdata;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Arbiter and slave agent: grants the requested bus and answers with ack pulses.
  initial begin : agent
    cmd_t p;
    int   w;
    gnt       = 1'b0;
    ack       = 1'b0;
    bus_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && req === 1'b1) begin
        if (plan_q.size() == 0) begin
          fail_now("req_without_cmd");
        end else begin
          p = plan_q.pop_front();
          check("slave_id_req", slave_id, p.addr[7]);
          w = 0;
          while (hold_gnt && w < 3000) begin
            @(negedge clk);
            w++;
          end
          if (hold_gnt) fail_now("hold_release");
          repeat (p.gnt_dly) begin
            check("req_wait", req, 1);
            check("bus_en_wait", bus_en, 0);
            @(negedge clk);
          end
          gnt = 1'b1;
          @(negedge clk);
          check("bus_en", bus_en, 1);
          check("bus_we", bus_we, p.we);
          check("bus_addr", bus_addr, p.addr);
          check("bus_wdata", bus_wdata, p.wdata);
          check("slave_id_xfer", slave_id, p.addr[7]);
`ifdef BMIF_TIMEOUT_EN
          if (p.ack_len == 0) begin
            repeat (TO) begin
              check("tmo_early", rsp_valid, 0);
              @(negedge clk);
            end
            check("tmo_rsp_valid", rsp_valid, 1);
            check("tmo_rsp_err", rsp_err, 1);
            check("tmo_req_drop", req, 0);
          end else
`endif
          begin
            for (int i = 0; i < p.ack_len; i++) begin
              ack       = 1'b1;
              bus_rdata = (i == p.ack_len - 1) ? p.rdf : ((i == 0) ? p.rd0 : 8'($urandom));
              if ($urandom_range(0, 3) == 0) gnt = 1'b0;
              @(negedge clk);
            end
            ack       = 1'b0;
            bus_rdata = 8'($urandom);
            @(negedge clk);
            check("retire_req", req, 0);
            check("retire_bus_en", bus_en, 0);
          end
          if (gnt) begin
            repeat (p.hold) begin
              @(negedge clk);
              check("gap_req", req, 0);
            end
          end
          gnt = 1'b0;
        end
      end
    end
  end

  // Response monitor.
  initial begin : monitor
    cmd_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rsp_unexpected: actual=rsp_valid required=none");
        end else begin
          e = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, e.exp_rd);
          check("rsp_err", rsp_err, e.exp_err);
        end
      end
    end
  end

  initial begin : main
    cmd_t c;
    int   w;
    rst       = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 8'h81;
    cmd_wdata = 8'h11;
    repeat (2) begin
      @(negedge clk);
      check("rst_req", req, 0);
      check("rst_bus_en", bus_en, 0);
      check("rst_rsp_valid", rsp_valid, 0);
    end
    rst       = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_slave_id", slave_id, 0);
    check("rst_bus_addr", bus_addr, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    @(negedge clk);
    check("rst_no_push", req, 0);

    // Fill the FIFO with the grant withheld, then let 6 transfers drain through it.
    hold_gnt = 1'b1;
    repeat (4) push_cmd(rand_cmd());
    @(negedge clk);
    check("full_cmd_ready", cmd_ready, 0);
    repeat (10) begin
      check("delay_req", req, 1);
      check("delay_bus_en", bus_en, 0);
      @(negedge clk);
    end
    hold_gnt = 1'b0;
    repeat (2) push_cmd(rand_cmd());

    c = rand_cmd();
    c.we = 1'b1; c.addr = 8'h85; c.wdata = 8'h3C; c.ack_len = 2; c.gnt_dly = 1; c.hold = 1;
    push_cmd(c);
    c = rand_cmd();
    c.we = 1'b0; c.addr = 8'h10; c.rd0 = 8'hA5; c.rdf = 8'h5A; c.ack_len = 2;
    push_cmd(c);

    repeat (40) begin
      repeat ($urandom_range(0, 4)) @(negedge clk);
      push_cmd(rand_cmd());
    end

`ifdef BMIF_TIMEOUT_EN
    c = rand_cmd();
    c.ack_len = 0;
    push_cmd(c);
    push_cmd(rand_cmd());
`endif

    w = 0;
    while (exp_q.size() != 0 && w < 5000) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) fail_now("drain");
    repeat (5) @(negedge clk);
    check("final_req", req, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
